// File: rtl/noc_pkg.sv
// Shared ring-NoC definitions: flit field positions, route tags and the
// global phase encoding used by input controllers and output arbiters.
package noc_pkg;

    localparam int DATA_W  = 64;
    localparam int VC_BIT  = 63;
    localparam int DIR_BIT = 62;
    localparam int HOP_MSB = 55;
    localparam int HOP_LSB = 48;
    localparam int HOP_W   = HOP_MSB - HOP_LSB + 1;

    // Where a buffered flit goes next: onward along the ring or to the local PE.
    typedef enum logic {
        ROUTE_FWD = 1'b0,
        ROUTE_PE  = 1'b1
    } route_t;

    // Global phase: VC0 moves downstream in the odd phase, VC1 in the even one.
    localparam logic PHASE_ODD  = 1'b0;
    localparam logic PHASE_EVEN = 1'b1;

    // Return the flit with its hop field reduced by one; all other bits kept.
    function automatic logic [DATA_W-1:0] hop_dec(input logic [DATA_W-1:0] flit);
        logic [DATA_W-1:0] res;
        res = flit;
        res[HOP_MSB:HOP_LSB] = flit[HOP_MSB:HOP_LSB] - HOP_W'(1);
        return res;
    endfunction

endpackage

// File: rtl/vc_slot.sv
// One-flit buffer for a single virtual channel: holds the flit, its valid
// bit and its route tag. The hop field is decremented at load time for
// flits that continue along the ring.
import noc_pkg::*;

module vc_slot (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] din,
    output logic              valid,
    output route_t            tag,
    output logic [DATA_W-1:0] dout
);

    logic hop_zero;
    assign hop_zero = (din[HOP_MSB:HOP_LSB] == '0);

    // Slot register: load wins over clear; data is held after release.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (reset) begin
            valid <= 1'b0;
            tag   <= ROUTE_FWD;
            // NOTE: the data buffer is reset too, so dout reads as zero until the first flit.
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            if (hop_zero) begin
                tag  <= ROUTE_PE;
                dout <= din;
            end else begin
                tag  <= ROUTE_FWD;
                dout <= hop_dec(din);
            end
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ring_input_ctrl.sv
// Input-channel controller for one ring router port. Buffers one flit per
// VC, handshakes with upstream via si/ri, raises per-VC requests in the
// phase that VC is allowed to move, and releases a slot on its grant pulse.
import noc_pkg::*;

module ring_input_ctrl (
    input  logic              clk,
    input  logic              reset,
    input  logic              state,
    input  logic              si,
    input  logic [DATA_W-1:0] di,
    output logic              ri,
    output logic              req_fwd_vc0,
    output logic              req_fwd_vc1,
    output logic              req_pe_vc0,
    output logic              req_pe_vc1,
    output logic [DATA_W-1:0] dout_vc0,
    output logic [DATA_W-1:0] dout_vc1,
    input  logic              gnt_vc0,
    input  logic              gnt_vc1,
    output logic              err,
    output logic [15:0]       acc_cnt
);

    logic [1:0] valid;
    logic [1:0] load;
    logic [1:0] clear;
    logic [1:0] gnt;
    route_t     tag0;
    route_t     tag1;
    logic       wr_vc;
    logic       legal_vc;
    logic       accept;
    logic       bad_send;
    logic       wr_gnt_clash;

    // Upstream may only fill the VC that is not moving downstream this phase.
    assign ri       = ~valid[~state];
    assign wr_vc    = di[VC_BIT];
    assign legal_vc = (wr_vc != state);
    assign accept   = si & ri & legal_vc;
    assign bad_send = si & (~ri | ~legal_vc);

    assign gnt   = {gnt_vc1, gnt_vc0};
    assign load  = {accept & wr_vc, accept & ~wr_vc};
    // Grants on empty slots are ignored; they only release a held flit.
    assign clear = gnt & valid;
    assign wr_gnt_clash = |(load & gnt);

    vc_slot u_slot_vc0 (
        .clk   (clk),
        .reset (reset),
        .load  (load[0]),
        .clear (clear[0]),
        .din   (di),
        .valid (valid[0]),
        .tag   (tag0),
        .dout  (dout_vc0)
    );

    vc_slot u_slot_vc1 (
        .clk   (clk),
        .reset (reset),
        .load  (load[1]),
        .clear (clear[1]),
        .din   (di),
        .valid (valid[1]),
        .tag   (tag1),
        .dout  (dout_vc1)
    );

    // Per-VC requests, only in the phase in which that VC may move.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        req_fwd_vc0 = 1'b0;
        req_pe_vc0  = 1'b0;
        req_fwd_vc1 = 1'b0;
        req_pe_vc1  = 1'b0;
        if (valid[0] && state == PHASE_ODD) begin
            req_fwd_vc0 = (tag0 == ROUTE_FWD);
            req_pe_vc0  = (tag0 == ROUTE_PE);
        end
        if (valid[1] && state == PHASE_EVEN) begin
            req_fwd_vc1 = (tag1 == ROUTE_FWD);
            req_pe_vc1  = (tag1 == ROUTE_PE);
        end
    end

    // Sticky protocol error: illegal send, or a grant colliding with a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (bad_send || wr_gnt_clash) begin
            err <= 1'b1;
        end
    end

    // Saturating count of accepted flits.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_cnt <= '0;
        end else if (accept && acc_cnt != 16'hFFFF) begin
            acc_cnt <= acc_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ring_input_ctrl.sv
// Directed self-checking bench for ring_input_ctrl.
module tb_ring_input_ctrl;

    logic        clk;
    logic        reset;
    logic        state;
    logic        si;
    logic [63:0] di;
    logic        ri;
    logic        req_fwd_vc0, req_fwd_vc1, req_pe_vc0, req_pe_vc1;
    logic [63:0] dout_vc0, dout_vc1;
    logic        gnt_vc0, gnt_vc1;
    logic        err;
    logic [15:0] acc_cnt;

    int n_total  = 0;
    int n_passed = 0;

    ring_input_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .si          (si),
        .di          (di),
        .ri          (ri),
        .req_fwd_vc0 (req_fwd_vc0),
        .req_fwd_vc1 (req_fwd_vc1),
        .req_pe_vc0  (req_pe_vc0),
        .req_pe_vc1  (req_pe_vc1),
        .dout_vc0    (dout_vc0),
        .dout_vc1    (dout_vc1),
        .gnt_vc0     (gnt_vc0),
        .gnt_vc1     (gnt_vc1),
        .err         (err),
        .acc_cnt     (acc_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Flit layout: [63] vc, [62] dir, [55:48] hop, [31:0] payload.
    function automatic logic [63:0] mk_flit(input logic vc, input logic dir,
                                            input logic [7:0] hop, input logic [31:0] data);
        return {vc, dir, 6'b0, hop, 16'h0000, data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; si = 1'b0; gnt_vc0 = 1'b0; gnt_vc1 = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        state = 1'b0;
        do_reset();
        #1;
        n_total++; if (ri !== 1'b1) $display("FAIL reset_ri got=%b exp=1", ri); else n_passed++;
        n_total++; if ({req_fwd_vc0, req_pe_vc0, req_fwd_vc1, req_pe_vc1} !== 4'b0)
            $display("FAIL reset_req got=%b exp=0000", {req_fwd_vc0, req_pe_vc0, req_fwd_vc1, req_pe_vc1});
        else n_passed++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_passed++;
        n_total++; if (acc_cnt !== 16'd0) $display("FAIL reset_acc got=%0d exp=0", acc_cnt); else n_passed++;
        n_total++; if (dout_vc0 !== 64'd0 || dout_vc1 !== 64'd0)
            $display("FAIL reset_dout got=%h/%h exp=0", dout_vc0, dout_vc1);
        else n_passed++;
    endtask

    task automatic test_fwd_vc0();
        state = 1'b1; si = 1'b1; di = mk_flit(1'b0, 1'b0, 8'h02, 32'hA5A5A5A5);
        #1;
        n_total++; if (ri !== 1'b1) $display("FAIL fwd_ri got=%b exp=1", ri); else n_passed++;
        tick();
        si = 1'b0;
        #1;
        n_total++; if (req_fwd_vc0 !== 1'b0) $display("FAIL fwd_req_masked got=%b exp=0", req_fwd_vc0); else n_passed++;
        state = 1'b0;
        #1;
        n_total++; if (req_fwd_vc0 !== 1'b1 || req_pe_vc0 !== 1'b0)
            $display("FAIL fwd_req got=%b%b exp=10", req_fwd_vc0, req_pe_vc0);
        else n_passed++;
        n_total++; if (dout_vc0 !== mk_flit(1'b0, 1'b0, 8'h01, 32'hA5A5A5A5))
            $display("FAIL fwd_dout got=%h exp=%h", dout_vc0, mk_flit(1'b0, 1'b0, 8'h01, 32'hA5A5A5A5));
        else n_passed++;
        tick();
        state = 1'b1; gnt_vc0 = 1'b1;
        tick();
        gnt_vc0 = 1'b0; state = 1'b0;
        #1;
        n_total++; if (req_fwd_vc0 !== 1'b0 || req_pe_vc0 !== 1'b0)
            $display("FAIL fwd_release got=%b%b exp=00", req_fwd_vc0, req_pe_vc0);
        else n_passed++;
        n_total++; if (acc_cnt !== 16'd1) $display("FAIL fwd_acc got=%0d exp=1", acc_cnt); else n_passed++;
        n_total++; if (dout_vc0 !== mk_flit(1'b0, 1'b0, 8'h01, 32'hA5A5A5A5))
            $display("FAIL fwd_dout_hold got=%h", dout_vc0);
        else n_passed++;
    endtask

    task automatic test_pe_vc1();
        logic [63:0] f;
        f = mk_flit(1'b1, 1'b1, 8'h00, 32'h0BADCAFE);
        state = 1'b0; si = 1'b1; di = f;
        tick();
        si = 1'b0;
        #1;
        n_total++; if (req_pe_vc1 !== 1'b0) $display("FAIL pe_req_masked got=%b exp=0", req_pe_vc1); else n_passed++;
        state = 1'b1;
        #1;
        n_total++; if (req_pe_vc1 !== 1'b1 || req_fwd_vc1 !== 1'b0)
            $display("FAIL pe_req got=%b%b exp=10", req_pe_vc1, req_fwd_vc1);
        else n_passed++;
        n_total++; if (dout_vc1 !== f) $display("FAIL pe_dout got=%h exp=%h", dout_vc1, f); else n_passed++;
        tick();
        state = 1'b0; gnt_vc1 = 1'b1;
        tick();
        gnt_vc1 = 1'b0; state = 1'b1;
        #1;
        n_total++; if (req_pe_vc1 !== 1'b0) $display("FAIL pe_release got=%b exp=0", req_pe_vc1); else n_passed++;
        n_total++; if (acc_cnt !== 16'd2) $display("FAIL pe_acc got=%0d exp=2", acc_cnt); else n_passed++;
    endtask

    task automatic test_ri_full();
        logic [63:0] f;
        f = mk_flit(1'b0, 1'b0, 8'h03, 32'h11112222);
        do_reset();
        state = 1'b1; si = 1'b1; di = f;
        tick();
        si = 1'b0;
        #1;
        n_total++; if (ri !== 1'b0) $display("FAIL full_ri_even got=%b exp=0", ri); else n_passed++;
        state = 1'b0;
        #1;
        n_total++; if (ri !== 1'b1) $display("FAIL full_ri_odd got=%b exp=1", ri); else n_passed++;
        tick();
        state = 1'b1;
        #1;
        n_total++; if (ri !== 1'b0) $display("FAIL full_ri_even2 got=%b exp=0", ri); else n_passed++;
        si = 1'b1; di = mk_flit(1'b0, 1'b0, 8'h09, 32'h33334444);
        tick();
        si = 1'b0;
        #1;
        n_total++; if (err !== 1'b1) $display("FAIL full_err got=%b exp=1", err); else n_passed++;
        n_total++; if (acc_cnt !== 16'd1) $display("FAIL full_acc got=%0d exp=1", acc_cnt); else n_passed++;
        n_total++; if (dout_vc0 !== mk_flit(1'b0, 1'b0, 8'h02, 32'h11112222))
            $display("FAIL full_dout got=%h", dout_vc0);
        else n_passed++;
    endtask

    task automatic test_wrong_vc();
        do_reset();
        state = 1'b0; si = 1'b1; di = mk_flit(1'b0, 1'b0, 8'h00, 32'hDEADBEEF);
        tick();
        si = 1'b0;
        #1;
        n_total++; if (err !== 1'b1) $display("FAIL wrongvc_err got=%b exp=1", err); else n_passed++;
        n_total++; if (acc_cnt !== 16'd0) $display("FAIL wrongvc_acc got=%0d exp=0", acc_cnt); else n_passed++;
        n_total++; if (req_pe_vc0 !== 1'b0 || req_fwd_vc0 !== 1'b0)
            $display("FAIL wrongvc_drop got=%b%b exp=00", req_pe_vc0, req_fwd_vc0);
        else n_passed++;
        for (int i = 0; i < 4; i++) begin
            state = ~state;
            tick();
        end
        n_total++; if (err !== 1'b1) $display("FAIL wrongvc_sticky got=%b exp=1", err); else n_passed++;
        do_reset();
        #1;
        n_total++; if (err !== 1'b0) $display("FAIL wrongvc_clear got=%b exp=0", err); else n_passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  hop0 [5];
        logic [7:0]  hop1 [5];
        logic [63:0] e;
        int tx0, tx1, rx0, rx1;
        logic g0, g1;
        hop0 = '{8'h02, 8'h00, 8'h07, 8'h00, 8'h01};
        hop1 = '{8'h00, 8'h03, 8'h00, 8'h01, 8'hFF};
        tx0 = 0; tx1 = 0; rx0 = 0; rx1 = 0; g0 = 1'b0; g1 = 1'b0;
        do_reset();
        for (int t = 0; t < 22; t++) begin
            state = t[0];
            gnt_vc0 = g0; gnt_vc1 = g1; g0 = 1'b0; g1 = 1'b0;
            si = 1'b0;
            if (t % 4 == 0 && tx1 < 5) begin
                si = 1'b1; di = mk_flit(1'b1, 1'b1, hop1[tx1], 32'h10000000 + tx1); tx1++;
            end else if (t % 4 == 1 && tx0 < 5) begin
                si = 1'b1; di = mk_flit(1'b0, 1'b0, hop0[tx0], 32'h20000000 + tx0); tx0++;
            end
            #1;
            if (si) begin
                n_total++; if (ri !== 1'b1) $display("FAIL b2b_ri t=%0d got=%b exp=1", t, ri); else n_passed++;
            end
            if (state == 1'b0) begin
                n_total++; if (req_fwd_vc1 !== 1'b0 || req_pe_vc1 !== 1'b0)
                    $display("FAIL b2b_vc1_phase t=%0d got=%b%b exp=00", t, req_fwd_vc1, req_pe_vc1);
                else n_passed++;
                if (req_fwd_vc0 === 1'b1 || req_pe_vc0 === 1'b1) begin
                    n_total++;
                    if (rx0 >= 5) $display("FAIL b2b_vc0_extra t=%0d got=%h exp=none", t, dout_vc0);
                    else begin
                        e = mk_flit(1'b0, 1'b0, (hop0[rx0] == 8'h00) ? 8'h00 : hop0[rx0] - 8'h01, 32'h20000000 + rx0);
                        if (dout_vc0 !== e || req_pe_vc0 !== (hop0[rx0] == 8'h00))
                            $display("FAIL b2b_vc0 n=%0d got=%h pe=%b exp=%h", rx0, dout_vc0, req_pe_vc0, e);
                        else n_passed++;
                    end
                    rx0++; g0 = 1'b1;
                end
            end else begin
                n_total++; if (req_fwd_vc0 !== 1'b0 || req_pe_vc0 !== 1'b0)
                    $display("FAIL b2b_vc0_phase t=%0d got=%b%b exp=00", t, req_fwd_vc0, req_pe_vc0);
                else n_passed++;
                if (req_fwd_vc1 === 1'b1 || req_pe_vc1 === 1'b1) begin
                    n_total++;
                    if (rx1 >= 5) $display("FAIL b2b_vc1_extra t=%0d got=%h exp=none", t, dout_vc1);
                    else begin
                        e = mk_flit(1'b1, 1'b1, (hop1[rx1] == 8'h00) ? 8'h00 : hop1[rx1] - 8'h01, 32'h10000000 + rx1);
                        if (dout_vc1 !== e || req_pe_vc1 !== (hop1[rx1] == 8'h00))
                            $display("FAIL b2b_vc1 n=%0d got=%h pe=%b exp=%h", rx1, dout_vc1, req_pe_vc1, e);
                        else n_passed++;
                    end
                    rx1++; g1 = 1'b1;
                end
            end
            tick();
        end
        si = 1'b0; gnt_vc0 = 1'b0; gnt_vc1 = 1'b0;
        #1;
        n_total++; if (rx0 != 5 || rx1 != 5) $display("FAIL b2b_count got=%0d/%0d exp=5/5", rx0, rx1); else n_passed++;
        n_total++; if (acc_cnt !== 16'd10) $display("FAIL b2b_acc got=%0d exp=10", acc_cnt); else n_passed++;
        n_total++; if (err !== 1'b0) $display("FAIL b2b_err got=%b exp=0", err); else n_passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        state = 1'b0; si = 1'b1; di = mk_flit(1'b1, 1'b1, 8'h04, 32'hAAAA0001);
        tick();
        state = 1'b1; si = 1'b1; di = mk_flit(1'b0, 1'b0, 8'h05, 32'hAAAA0002);
        tick();
        state = 1'b0; si = 1'b1; di = mk_flit(1'b0, 1'b0, 8'h06, 32'hAAAA0003);
        tick();
        si = 1'b0;
        #1;
        n_total++; if (err !== 1'b1 || acc_cnt !== 16'd2 || req_fwd_vc0 !== 1'b1)
            $display("FAIL mid_setup got=err%b acc%0d req%b exp=err1 acc2 req1", err, acc_cnt, req_fwd_vc0);
        else n_passed++;
        state = 1'b1; gnt_vc0 = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; gnt_vc0 = 1'b0;
        #1;
        n_total++; if ({req_fwd_vc0, req_pe_vc0, req_fwd_vc1, req_pe_vc1} !== 4'b0 || ri !== 1'b1)
            $display("FAIL mid_even got=%b ri=%b exp=0000 ri=1", {req_fwd_vc0, req_pe_vc0, req_fwd_vc1, req_pe_vc1}, ri);
        else n_passed++;
        state = 1'b0;
        #1;
        n_total++; if ({req_fwd_vc0, req_pe_vc0, req_fwd_vc1, req_pe_vc1} !== 4'b0 || ri !== 1'b1)
            $display("FAIL mid_odd got=%b ri=%b exp=0000 ri=1", {req_fwd_vc0, req_pe_vc0, req_fwd_vc1, req_pe_vc1}, ri);
        else n_passed++;
        n_total++; if (acc_cnt !== 16'd0 || err !== 1'b0)
            $display("FAIL mid_cnt got=acc%0d err%b exp=acc0 err0", acc_cnt, err);
        else n_passed++;
    endtask

    initial begin
        reset = 1'b1; state = 1'b0; si = 1'b0; di = '0; gnt_vc0 = 1'b0; gnt_vc1 = 1'b0;
        tick();
        test_reset();
        test_fwd_vc0();
        test_pe_vc1();
        test_ri_full();
        test_wrong_vc();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/ring_input_ctrl.md
Name: ring_input_ctrl

Overview:
- Input-channel controller for one ring router port (CW, CCW or PE input).
- Holds one flit per virtual channel (VC0/VC1) and runs the upstream si/ri handshake.
- Routes each flit on its hop field and raises per-VC requests toward the downstream output arbiters.
- Releases a flit when the arbiter's one-cycle grant flag returns, interleaving VCs under the global even/odd phase.

Parameters:
DATA_W, 64, flit width
VC_BIT, 63, flit bit selecting VC (0=VC0, 1=VC1)
DIR_BIT, 62, direction bit (0=CW, 1=CCW), passed through unchanged
HOP_MSB, 55, hop-count field MSB
HOP_LSB, 48, hop-count field LSB (8-bit hop field)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high
state  in  1  global phase: 0 = odd (VC0 forwarded downstream), 1 = even (VC1 forwarded)
si  in  1  upstream send strobe, flit valid on di
di  in  DATA_W  upstream flit
ri  out  1  ready to upstream
req_fwd_vc0 / req_fwd_vc1  out  1  request to next-hop output arbiter, per VC
req_pe_vc0 / req_pe_vc1  out  1  request to local PE output arbiter, per VC
dout_vc0 / dout_vc1  out  DATA_W  buffered flit per VC, hop field already decremented when forwarding
gnt_vc0 / gnt_vc1  in  1  grant/cancel flag from the output arbiter, one-cycle pulse
err  out  1  sticky protocol error
acc_cnt  out  16  accepted-flit counter, saturating

Behaviour:
- Reset: all valid bits 0, buffers 0, err 0, acc_cnt 0. Consequently ri = 1 (both slots empty) and all req_* = 0.
- Intake:
  - ri = ~valid[~state] (combinational). Upstream may only send the VC not being forwarded this phase.
  - Accept when si & ri: flit stored into slot di[VC_BIT]; valid set next edge; acc_cnt +1, saturating at 16'hFFFF.
- Error:
  - If si & di[VC_BIT] == state, the flit is dropped and err is set, sticky until reset.
  - If si & ~ri, the flit is dropped and err is set.
- Routing at write time:
  - hop == 0: slot tagged PE; flit stored unmodified.
  - hop != 0: slot tagged FWD; flit stored with hop − 1 (8-bit, no wrap since hop != 0). All other fields unchanged.
- Request generation (combinational):
  - req_fwd_vcN = valid[N] & tag[N]==FWD & (state==N).
  - req_pe_vcN = valid[N] & tag[N]==PE & (state==N).
  - At most one of the two is high per VC.
- Release: on any edge where gnt_vcN = 1 and valid[N] = 1, valid[N] clears. A grant with valid[N] = 0 is ignored and err is not set.
- Grant timing:
  - Arbiter grants are registered, so gnt_vcN arrives one cycle after the request, when state has toggled.
  - The request is therefore already masked, and no double grant is possible.
  - Minimum slot occupancy is 2 cycles.
- Same-cycle grant and intake: ri does not reflect a same-cycle clear. A slot cleared on edge t is writable from edge t+1 onward.
- Simultaneous write and grant on the same slot cannot occur: a write needs valid = 0 and a grant needs valid = 1. If it arises from an illegal stimulus, the write wins and err is set.
- dout_vcN is held stable while valid[N] = 1 and keeps its last value after release.
- A reset asserted mid-operation discards both slots on the next edge; an in-flight grant is ignored.

Decomposition:
- Package noc_pkg:
  - DATA_W
  - field positions VC_BIT, DIR_BIT, HOP_MSB, HOP_LSB
  - route tag constants ROUTE_FWD / ROUTE_PE
  - phase constants PHASE_ODD = 0, PHASE_EVEN = 1 (shared with the output arbiter)
- Sub-module vc_slot: one-flit register plus valid/tag, with load, clear and hop-decrement. Instantiated twice, for VC0 and VC1.

Test Plan:
- Reset then state=1, si=1, di={VC=0, hop=8'h02, data=32'hA5A5A5A5} → ri=1, slot0 valid; at state=0, req_fwd_vc0=1 and dout_vc0 hop=8'h01; gnt_vc0 pulse next cycle → valid clears, req drops, acc_cnt=1.
- state=0, send VC1 flit with hop=0 → req_pe_vc1=1 only while state=1, dout_vc1 unmodified; grant → released.
- Fill slot0, no grant, toggle phase → ri=0 whenever state=1; si during ri=0 → flit dropped, err=1, acc_cnt unchanged.
- state=0, si with di[63]=0 → dropped, err=1 and sticky until reset.
- Back-to-back traffic on alternating VCs with grants on every legal cycle, 10 flits → every flit appears exactly once, in order per VC; acc_cnt=10; req never high while state≠VC.
- Reset asserted with both slots full and gnt_vc0 pending → next cycle all req_*=0, ri=1, acc_cnt=0, err=0.
